// File: rtl/stepper_pkg.sv
// Shared types and command/status field positions for the stepper pulse generator.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } step_state_t;

  localparam int CMD_DIR_BIT     = 31;
  localparam int CMD_CNT_W       = 31;
  localparam int STATUS_BUSY_BIT = 31;

endpackage

// File: rtl/stepper_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
module stepper_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for one stepper axis.
// Optional endstop handling is compiled in with the STEPPER_ENDSTOP_EN macro.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int unsigned PULSE_W     = 4,
  parameter int unsigned DIR_SETUP   = 8,
  parameter logic        ENDSTOP_DIR = 1'b0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] speed_i,
  input  logic [31:0] cmd_i,
  input  logic        go_i,
  input  logic        endstop_i,
  output logic        step_o,
  output logic        dir_o,
  output logic [31:0] status_o
);

  localparam logic [31:0] PW_L    = 32'(PULSE_W);
  localparam logic [31:0] DS_L    = 32'(DIR_SETUP);
  localparam logic [31:0] MIN_PER = 32'(PULSE_W + 1);

  step_state_t          state_q, state_d;
  logic [31:0]          tmr_q, tmr_d;
  logic [31:0]          per_cnt_q, per_cnt_d;
  logic [31:0]          period_q, period_d;
  logic [CMD_CNT_W-1:0] count_q, count_d;
  logic [CMD_CNT_W-1:0] done_q, done_d;
  logic                 dirl_q, dirl_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 busy_q, busy_d;
  logic [31:0]          status_q, status_d;
  logic                 go_prev_q, go_prev_d;
  logic                 go_rise_q, go_rise_d;
  logic                 go_s;
  logic                 es_stop;
  logic                 stop;

  function automatic logic [CMD_CNT_W-1:0] sat_inc(input logic [CMD_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  stepper_sync2 u_go_sync (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .d_i   (go_i),
    .q_o   (go_s)
  );

`ifdef STEPPER_ENDSTOP_EN
  logic es_s;

  stepper_sync2 u_es_sync (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .d_i   (endstop_i),
    .q_o   (es_s)
  );

  // Only motion toward the endstop is blocked.
  assign es_stop = es_s & (dirl_q == ENDSTOP_DIR);
`else
  logic endstop_unused;
  assign endstop_unused = endstop_i;
  assign es_stop        = 1'b0;
`endif

  // Abort when software drops go, or when the endstop blocks this direction.
  assign stop = ~go_s | es_stop;

  // Next-state, counters and registered outputs of the move sequencer.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    count_d   = count_q;
    done_d    = done_q;
    dirl_d    = dirl_q;
    dir_d     = dir_q;
    go_prev_d = go_s;
    go_rise_d = go_s & ~go_prev_q;
    case (state_q)
      ST_IDLE: begin
        if (go_rise_q) begin
          count_d = cmd_i[CMD_CNT_W-1:0];
          dirl_d  = cmd_i[CMD_DIR_BIT];
          done_d  = '0;
          if (cmd_i[CMD_CNT_W-1:0] != '0) begin
            dir_d   = cmd_i[CMD_DIR_BIT];
            tmr_d   = 32'd1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tmr_q == DS_L) begin
          period_d  = (speed_i < MIN_PER) ? MIN_PER : speed_i;
          per_cnt_d = 32'd1;
          tmr_d     = 32'd1;
          state_d   = ST_PULSE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      ST_PULSE: begin
        per_cnt_d = per_cnt_q + 32'd1;
        if (tmr_q == PW_L) begin
          done_d  = sat_inc(done_q);
          state_d = stop ? ST_IDLE : ST_WAIT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      ST_WAIT: begin
        per_cnt_d = per_cnt_q + 32'd1;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (per_cnt_q == period_q) begin
          if (done_q == count_q) begin
            state_d = ST_IDLE;
          end else begin
            period_d  = (speed_i < MIN_PER) ? MIN_PER : speed_i;
            per_cnt_d = 32'd1;
            tmr_d     = 32'd1;
            state_d   = ST_PULSE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    step_d   = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
    status_d = {busy_q, done_q};
  end

  // State and datapath registers; reset also drops step_o immediately.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      per_cnt_q <= '0;
      period_q  <= '0;
      count_q   <= '0;
      done_q    <= '0;
      dirl_q    <= 1'b0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      status_q  <= '0;
      go_prev_q <= 1'b0;
      go_rise_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      count_q   <= count_d;
      done_q    <= done_d;
      dirl_q    <= dirl_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      status_q  <= status_d;
      go_prev_q <= go_prev_d;
      go_rise_q <= go_rise_d;
    end
  end

  assign step_o   = step_q;
  assign dir_o    = dir_q;
  assign status_o = status_q;

endmodule
